// File: rtl/seg_msg_pkg.sv
// seg_msg_pkg: character codes, font, states and play modes
// shared by the 7-segment message player.
package seg_msg_pkg;

    localparam int CHAR_BITS = 5;

    localparam logic [4:0] CH_0     = 5'd0;
    localparam logic [4:0] CH_1     = 5'd1;
    localparam logic [4:0] CH_2     = 5'd2;
    localparam logic [4:0] CH_3     = 5'd3;
    localparam logic [4:0] CH_4     = 5'd4;
    localparam logic [4:0] CH_5     = 5'd5;
    localparam logic [4:0] CH_6     = 5'd6;
    localparam logic [4:0] CH_7     = 5'd7;
    localparam logic [4:0] CH_8     = 5'd8;
    localparam logic [4:0] CH_9     = 5'd9;
    localparam logic [4:0] CH_A     = 5'd10;
    localparam logic [4:0] CH_B     = 5'd11;
    localparam logic [4:0] CH_C     = 5'd12;
    localparam logic [4:0] CH_D     = 5'd13;
    localparam logic [4:0] CH_E     = 5'd14;
    localparam logic [4:0] CH_F     = 5'd15;
    localparam logic [4:0] CH_H     = 5'd16;
    localparam logic [4:0] CH_I     = 5'd17;
    localparam logic [4:0] CH_L     = 5'd18;
    localparam logic [4:0] CH_O     = 5'd19;
    localparam logic [4:0] CH_P     = 5'd20;
    localparam logic [4:0] CH_S     = 5'd21;
    localparam logic [4:0] CH_U     = 5'd22;
    localparam logic [4:0] CH_R     = 5'd23;
    localparam logic [4:0] CH_N     = 5'd24;
    localparam logic [4:0] CH_T     = 5'd25;
    localparam logic [4:0] CH_Y     = 5'd26;
    localparam logic [4:0] CH_DASH  = 5'd27;
    localparam logic [4:0] CH_BLANK = 5'd28;

    // Active-high {g,f,e,d,c,b,a}; codes 28..31 are dark.
    localparam logic [6:0] FONT [32] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
        7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79,
        7'h71, 7'h76, 7'h30, 7'h38, 7'h3F,
        7'h73, 7'h6D, 7'h3E, 7'h50, 7'h54,
        7'h78, 7'h6E, 7'h40, 7'h00, 7'h00,
        7'h00, 7'h00
    };

    localparam logic [1:0] MODE_LOOP     = 2'b00;
    localparam logic [1:0] MODE_ONESHOT  = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_GAPLOOP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_GAP,
        ST_DONE
    } state_t;

    // "HELLO ASIC", char 0 in the LSBs
    localparam logic [49:0] MSG_HELLO_ASIC = {
        CH_C, CH_I, CH_S, CH_A, CH_BLANK,
        CH_O, CH_L, CH_L, CH_E, CH_H
    };

endpackage

// File: rtl/seg_font_rom.sv
// seg_font_rom: character code to active-high segments.
// Undefined codes render blank.
module seg_font_rom
    import seg_msg_pkg::*;
(
    input  logic [CHAR_BITS-1:0] i_code,
    output logic [6:0]           o_seg
);

    // Plain table lookup, polarity is applied by the caller
    always_comb begin
        o_seg = FONT[i_code];
    end

endmodule

// File: rtl/seg_msg_player.sv
// seg_msg_player: plays a fixed message on one 7-seg digit.
// Optional macro SEG_DP_HEARTBEAT_EN toggles dp per dwell.
module seg_msg_player
    import seg_msg_pkg::*;
#(
    parameter int MSG_LEN        = 10,
    parameter int CHAR_W         = CHAR_BITS,
    parameter logic [MSG_LEN*CHAR_W-1:0] MSG = MSG_HELLO_ASIC,
    parameter int DWELL_MIN_LOG2 = 20,
    parameter int SPEED_W        = 3,
    parameter bit COMMON_ANODE   = 1'b1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               run,
    input  logic               restart,
    input  logic [1:0]         mode,
    input  logic [SPEED_W-1:0] speed,
    output logic [7:0]         seg_out,
    output logic [((MSG_LEN > 1) ? $clog2(MSG_LEN) : 1)-1:0] char_idx,
    output logic               busy,
    output logic               done
);

    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int CNT_W = DWELL_MIN_LOG2 + (1 << SPEED_W) - 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(MSG_LEN - 1);
    localparam logic [7:0] POL = {8{COMMON_ANODE}};

    state_t             r_state, w_state;
    logic [IDX_W-1:0]   r_idx, w_idx;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic               r_dir, w_dir;
    logic [7:0]         r_seg;
    logic               r_busy, r_done;
    logic [CNT_W-1:0]   w_lim;
    logic               w_exp;
    logic               w_last;
    logic               w_act;
    logic [CHAR_BITS-1:0] w_code;
    logic [6:0]         w_font;
    logic               w_dp;

    // Shifting all-ones right by ~speed gives 2^(min+speed)-1
    assign w_lim  = {CNT_W{1'b1}} >> (~speed);
    assign w_exp  = (r_cnt >= w_lim);
    assign w_last = (r_idx == LAST);
    assign w_act  = (w_state == ST_SHOW) || (w_state == ST_GAP);
    assign w_code = MSG[int'(w_idx)*CHAR_W +: CHAR_W];

    seg_font_rom u_font (
        .i_code (w_code),
        .o_seg  (w_font)
    );

`ifdef SEG_DP_HEARTBEAT_EN
    logic r_dp;
    logic w_tick;

    assign w_tick = run && w_exp &&
        ((r_state == ST_SHOW) || (r_state == ST_GAP));

    // Heartbeat flips per expiry while playing, dark otherwise
    always_comb begin
        w_dp = 1'b0;
        if (!restart && w_act)
            w_dp = r_dp ^ w_tick;
    end

    // Heartbeat register
    always_ff @(posedge CLK) begin
        if (!RST_N) r_dp <= 1'b0;
        else        r_dp <= w_dp;
    end
`else
    assign w_dp = 1'b0;
`endif

    // Next-state decision: restart, then per-state play rules
    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_cnt   = r_cnt;
        w_dir   = r_dir;
        if (mode != MODE_PINGPONG)
            w_dir = 1'b0;
        if (restart) begin
            w_state = run ? ST_SHOW : ST_IDLE;
            w_idx   = '0;
            w_cnt   = '0;
            w_dir   = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        w_state = ST_SHOW;
                        w_idx   = '0;
                        w_cnt   = '0;
                        w_dir   = 1'b0;
                    end
                end
                ST_GAP: begin
                    if (run && w_exp) begin
                        w_cnt   = '0;
                        w_state = ST_SHOW;
                        w_idx   = '0;
                    end else if (run) begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (run && w_exp) begin
                        w_cnt = '0;
                        case (mode)
                            MODE_LOOP:
                                w_idx = w_last ? '0 : r_idx + 1'b1;
                            MODE_ONESHOT:
                                if (w_last) w_state = ST_DONE;
                                else        w_idx = r_idx + 1'b1;
                            MODE_GAPLOOP:
                                if (w_last) w_state = ST_GAP;
                                else        w_idx = r_idx + 1'b1;
                            default: begin
                                if (MSG_LEN == 1) begin
                                    w_idx = '0;
                                end else if (!r_dir) begin
                                    if (w_last) begin
                                        w_dir = 1'b1;
                                        w_idx = r_idx - 1'b1;
                                    end else begin
                                        w_idx = r_idx + 1'b1;
                                    end
                                end else begin
                                    if (r_idx == '0) begin
                                        w_dir = 1'b0;
                                        w_idx = IDX_W'(1);
                                    end else begin
                                        w_idx = r_idx - 1'b1;
                                    end
                                end
                            end
                        endcase
                    end else if (run) begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                end
            endcase
        end
    end

    // Sequencer state and registered outputs move together
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_seg   <= POL;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            r_dir   <= w_dir;
            r_seg   <= {w_dp, (w_state == ST_SHOW) ? w_font : 7'h00}
                       ^ POL;
            r_busy  <= w_act;
            r_done  <= (w_state == ST_DONE);
        end
    end

    assign seg_out  = r_seg;
    assign char_idx = r_idx;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
